// File: rtl/hex_inv_selftest_pkg.sv
// Shared definitions for the hex inverter self-test sequencer.
// Contents: FSM state encoding, lane/pattern counts, default timing
// parameters and the stimulus pattern table.
// Optional feature macro used by the sequencer: HEXINV_LOOP_EN (soak mode).
package hex_inv_selftest_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_e;

  localparam int unsigned NUM_LANES           = 6;
  localparam int unsigned NUM_PATTERNS        = 14;
  localparam int unsigned DEFAULT_SETTLE      = 2;
  localparam int unsigned DEFAULT_SYNC_STAGES = 2;

  // 0: all low, 1: all high, 2..7: walking one, 8..13: walking zero.
  function automatic logic [5:0] pattern(input logic [3:0] idx);
    logic [5:0] p;
    p = '0;
    if (idx == 4'd0) begin
      p = '0;
    end else if (idx == 4'd1) begin
      p = '1;
    end else if (idx <= 4'd7) begin
      p = 6'b000001 << (idx - 4'd2);
    end else if (idx <= 4'd13) begin
      p = ~(6'b000001 << (idx - 4'd8));
    end
    return p;
  endfunction

endpackage

// File: rtl/hex_inv_selftest_if.sv
// Board-side bus of the hex inverter self-test sequencer.
//   start     : request a test run (driven by master)
//   y_in      : inverter lane outputs, asynchronous (driven by master side / board)
//   a_out     : stimulus to inverter lanes A1..A6
//   busy/done : run status, done is a one-cycle pulse
//   pass, fail_mask, err_cnt : result of the last run
//   pat_idx   : current pattern index
// The sequencer uses the slave modport; the controlling environment uses master.
interface hex_inv_selftest_if;
  logic       start;
  logic [5:0] a_out;
  logic [5:0] y_in;
  logic       busy;
  logic       done;
  logic       pass;
  logic [5:0] fail_mask;
  logic [3:0] err_cnt;
  logic [3:0] pat_idx;

  modport master (
    output start, y_in,
    input  a_out, busy, done, pass, fail_mask, err_cnt, pat_idx
  );

  modport slave (
    input  start, y_in,
    output a_out, busy, done, pass, fail_mask, err_cnt, pat_idx
  );
endinterface

// File: rtl/hex_inv_selftest_sync_bus2.sv
// sync_bus2: two-flop synchroniser for a multi-bit bus of independent lanes,
// with synchronous clear.
//   clk   : destination clock
//   rst   : synchronous active-high clear
//   d_i   : asynchronous input bus
//   q_o   : synchronised output bus
module sync_bus2
  import hex_inv_selftest_pkg::*;
#(
  parameter int unsigned WIDTH = NUM_LANES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] s1_q;
  logic [WIDTH-1:0] s2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/hex_inv_selftest.sv
// hex_inv_selftest: self-test sequencer for a six-lane hex inverter (Y = !A).
// Drives a 14-pattern sequence onto the A lanes, samples Y back through a
// free-running synchroniser and records per-lane mismatches.
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset (aborts a run without done)
//   bus  : hex_inv_selftest_if.slave (start, y_in in; a_out, busy, done,
//          pass, fail_mask, err_cnt, pat_idx out)
// Parameters:
//   SETTLE      : extra hold cycles before sampling, 0..13
//   SYNC_STAGES : synchroniser depth, fixed at 2
// Optional macro HEXINV_LOOP_EN: soak mode, repeats passes until one fails.
module hex_inv_selftest
  import hex_inv_selftest_pkg::*;
#(
  parameter int unsigned SETTLE      = DEFAULT_SETTLE,
  parameter int unsigned SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic                 clk,
  input  logic                 rst,
  hex_inv_selftest_if.slave    bus
);

  localparam logic [3:0] WAIT_LOAD = 4'(SETTLE + SYNC_STAGES - 1);
  localparam logic [3:0] LAST_PAT  = 4'(NUM_PATTERNS - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [5:0] a_out_q, a_out_d;
  logic [3:0] pat_q, pat_d;
  logic [5:0] fail_q, fail_d;
  logic [3:0] err_q, err_d;
  logic       pass_q, pass_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic [5:0] ys;
  logic [5:0] mismatch;

  sync_bus2 #(.WIDTH(NUM_LANES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (bus.y_in),
    .q_o (ys)
  );

  assign mismatch = ys ^ ~a_out_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_out_q <= '0;
      pat_q   <= '0;
      fail_q  <= '0;
      err_q   <= '0;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_out_q <= a_out_d;
      pat_q   <= pat_d;
      fail_q  <= fail_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_out_d = a_out_q;
    pat_d   = pat_q;
    fail_d  = fail_q;
    err_d   = err_q;
    pass_d  = pass_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_DRIVE;
          fail_d  = '0;
          err_d   = '0;
          pass_d  = 1'b0;
          pat_d   = '0;
          busy_d  = 1'b1;
        end
      end

      S_DRIVE: begin
        a_out_d = pattern(pat_q);
        cnt_d   = WAIT_LOAD;
        state_d = S_WAIT;
      end

      // Leaves on the cycle the counter reaches zero, so WAIT lasts
      // WAIT_LOAD cycles and each pattern is held SETTLE+SYNC_STAGES+1 cycles.
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = S_CHECK;
        end
      end

      S_CHECK: begin
        fail_d = fail_q | mismatch;
        if ((mismatch != '0) && (err_q != 4'd15)) begin
          err_d = err_q + 4'd1;
        end
        if (pat_q == LAST_PAT) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          pass_d  = (fail_d == '0);
          a_out_d = '0;
`ifdef HEXINV_LOOP_EN
          busy_d  = (fail_d == '0);
`else
          busy_d  = 1'b0;
`endif
        end else begin
          pat_d   = pat_q + 4'd1;
          state_d = S_DRIVE;
        end
      end

      S_DONE: begin
`ifdef HEXINV_LOOP_EN
        // A continuing soak pass uses this cycle as the drive of pattern 0,
        // keeping the pass period at exactly 14 pattern slots.
        if (busy_q) begin
          pat_d   = '0;
          a_out_d = pattern(4'd0);
          cnt_d   = WAIT_LOAD;
          state_d = S_WAIT;
        end else begin
          state_d = S_IDLE;
        end
`else
        state_d = S_IDLE;
`endif
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.a_out     = a_out_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.fail_mask = fail_q;
  assign bus.err_cnt   = err_q;
  assign bus.pat_idx   = pat_q;

endmodule

// File: tb/tb_hex_inv_selftest.sv
module tb_hex_inv_selftest;

  typedef struct {
    logic [5:0] mask;
    logic [3:0] err;
    logic       pass;
  } res_t;

  typedef struct {
    string      name;
    int         mode;
    logic [5:0] mask;
    logic [3:0] err;
    logic       pass;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   fault_mode = 0;
  int   checks = 0;
  int   failures = 0;

  res_t       sb_q[$];
  logic [5:0] pat_q[$];
  logic [5:0] exp_pat [14];
  vec_t       vecs [4];

  hex_inv_selftest_if bus ();

  hex_inv_selftest #(.SETTLE(2), .SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Lane model: healthy inverter with one cycle of delay, plus fault modes.
  function automatic logic [5:0] lane_model(input logic [5:0] a, input int mode);
    case (mode)
      1:       return ~a & 6'b110111;
      2:       return a;
      3:       return ~a | 6'b000001;
      default: return ~a;
    endcase
  endfunction

  always @(posedge clk) bus.y_in <= lane_model(bus.a_out, fault_mode);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_run(input logic [5:0] m, input logic [3:0] e, input logic p);
    res_t r;
    r.mask = m; r.err = e; r.pass = p;
    sb_q.push_back(r);
    for (int i = 0; i < 14; i++) pat_q.push_back(exp_pat[i]);
  endtask

  task automatic pop_result(input string tag);
    res_t r;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      r = sb_q.pop_front();
      check({tag, "_fail_mask"}, 32'(bus.fail_mask), 32'(r.mask));
      check({tag, "_err_cnt"}, 32'(bus.err_cnt), 32'(r.err));
      check({tag, "_pass"}, 32'(bus.pass), 32'(r.pass));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_a_out"}, 32'(bus.a_out), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
    check({tag, "_pass"}, 32'(bus.pass), 32'd0);
    check({tag, "_fail_mask"}, 32'(bus.fail_mask), 32'd0);
    check({tag, "_err_cnt"}, 32'(bus.err_cnt), 32'd0);
    check({tag, "_pat_idx"}, 32'(bus.pat_idx), 32'd0);
  endtask

  // One single-pass run; optionally pulses start mid-run (must be ignored).
  task automatic run_one(input string tag, input int mode, input logic [5:0] m,
                         input logic [3:0] e, input logic p, input bit mid_start);
    int done_cyc;
    int busy_cnt;
    done_cyc = -1;
    busy_cnt = 0;
    fault_mode = mode;
    repeat (4) @(negedge clk);
    push_run(m, e, p);
    bus.start = 1'b1;
    for (int cyc = 1; cyc <= 90 && done_cyc < 0; cyc++) begin
      @(negedge clk);
      if (cyc == 1) bus.start = 1'b0;
      if (mid_start && cyc == 27) begin
        check({tag, "_pat_at_mid_start"}, 32'(bus.pat_idx), 32'd5);
        bus.start = 1'b1;
      end
      if (mid_start && cyc == 28) bus.start = 1'b0;
      if (bus.busy) busy_cnt++;
      if (cyc >= 2 && cyc <= 67 && ((cyc - 2) % 5) == 0) begin
        check({tag, "_a_out"}, 32'(bus.a_out), 32'(pat_q.pop_front()));
        check({tag, "_pat_idx"}, 32'(bus.pat_idx), 32'((cyc - 2) / 5));
      end
      if (bus.done) begin
        done_cyc = cyc;
        check({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
        pop_result(tag);
      end
    end
    check({tag, "_done_cycle"}, 32'(done_cyc), 32'd71);
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd70);
    sb_q.delete();
    pat_q.delete();
    repeat (10) @(negedge clk);
    check({tag, "_done_pulse_width"}, 32'(bus.done), 32'd0);
    check({tag, "_busy_after"}, 32'(bus.busy), 32'd0);
    check({tag, "_mask_hold"}, 32'(bus.fail_mask), 32'(m));
    check({tag, "_err_hold"}, 32'(bus.err_cnt), 32'(e));
    check({tag, "_pass_hold"}, 32'(bus.pass), 32'(p));
  endtask

  initial begin
    exp_pat = '{6'b000000, 6'b111111,
                6'b000001, 6'b000010, 6'b000100, 6'b001000, 6'b010000, 6'b100000,
                6'b111110, 6'b111101, 6'b111011, 6'b110111, 6'b101111, 6'b011111};
    vecs[0] = '{"healthy",      0, 6'b000000, 4'd0,  1'b1};
    vecs[1] = '{"lane4_stuck0", 1, 6'b001000, 4'd7,  1'b0};
    vecs[2] = '{"no_invert",    2, 6'b111111, 4'd14, 1'b0};
    vecs[3] = '{"lane1_stuck1", 3, 6'b000001, 4'd7,  1'b0};

    bus.start = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

`ifdef HEXINV_LOOP_EN
    begin
      int ndone;
      int done_cyc [3];
      int busy_low;
      ndone = 0;
      busy_low = 0;
      fault_mode = 0;
      push_run(6'b000000, 4'd0, 1'b1);
      push_run(6'b000000, 4'd0, 1'b1);
      push_run(6'b000001, 4'd5, 1'b0);
      bus.start = 1'b1;
      for (int cyc = 1; cyc <= 260 && ndone < 3; cyc++) begin
        @(negedge clk);
        if (cyc == 1) bus.start = 1'b0;
        if (ndone == 2 && bus.pat_idx == 4'd7 && fault_mode == 0) fault_mode = 3;
        if (bus.done) begin
          done_cyc[ndone] = cyc;
          ndone++;
          pop_result("soak");
          check("soak_busy_at_done", 32'(bus.busy), (ndone < 3) ? 32'd1 : 32'd0);
        end else if (!bus.busy) begin
          busy_low++;
        end
      end
      check("soak_done_count", 32'(ndone), 32'd3);
      check("soak_busy_low", 32'(busy_low), 32'd0);
      if (ndone == 3) begin
        check("soak_done1", 32'(done_cyc[0]), 32'd71);
        check("soak_done2", 32'(done_cyc[1]), 32'd141);
        check("soak_done3", 32'(done_cyc[2]), 32'd211);
      end
      sb_q.delete();
      pat_q.delete();
      repeat (80) @(negedge clk);
      check("soak_stopped_busy", 32'(bus.busy), 32'd0);
      check("soak_stopped_mask", 32'(bus.fail_mask), 32'd1);
      fault_mode = 0;
    end
`else
    foreach (vecs[i]) begin
      run_one(vecs[i].name, vecs[i].mode, vecs[i].mask, vecs[i].err, vecs[i].pass, 1'b0);
    end

    run_one("start_while_busy", 0, 6'b000000, 4'd0, 1'b1, 1'b1);

    // Reset mid-run at pat_idx 6: immediate return to reset values, no done.
    begin
      bit seen6;
      int done_seen;
      seen6 = 1'b0;
      done_seen = 0;
      fault_mode = 2;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      for (int cyc = 0; cyc < 60 && !seen6; cyc++) begin
        @(negedge clk);
        if (bus.pat_idx == 4'd6) seen6 = 1'b1;
      end
      check("rst_reached_pat6", 32'(seen6), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_reset_outputs("rst_mid_run");
      for (int cyc = 0; cyc < 80; cyc++) begin
        @(negedge clk);
        if (bus.done || bus.busy) done_seen++;
      end
      check("rst_no_done", 32'(done_seen), 32'd0);
      run_one("after_rst", 0, 6'b000000, 4'd0, 1'b1, 1'b0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
